// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment display driver.
// Latches a packed hex value plus decimal points on a load strobe and swaps
// it onto the display only at frame boundaries, so a frame is never torn.
// Digits are scanned from a clock-enable prescaler. Each digit switch is
// followed by a guard gap that keeps digit_en off, to avoid ghosting.
// The prescaler divisor DIV = CLK_HZ/SCAN_HZ must satisfy DIV >= GUARD+2.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 125_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int GUARD          = 2,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_DIG = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank,
  output logic [7:0]              sevenseg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GRD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [GRD_W-1:0]      GUARD_V  = GRD_W'(GUARD);
  localparam logic [7:0]            SEG_INV  = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV  = (ACTIVE_LOW_DIG != 0) ? '1 : '0;

  // Hex glyphs, bits [6:0] = segments a..g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GRD_W-1:0]        guard_q, guard_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic                    wrap_q, frame_done_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic                    tick, wrap;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   onehot;
  logic [6:0]              glyph;

  assign tick   = (pre_q == PRE_LAST);
  assign wrap   = tick && (idx_q == IDX_LAST);
  assign onehot = NUM_DIGITS'(1) << idx_q;

  // Split the displayed value into per-digit nibbles.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = disp_val_q[4*gi +: 4];
  end

`ifdef SEG7_LZB_EN
  // lz_upper[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS:0] lz_upper;
  assign lz_upper[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz_upper[gi] = (nib[gi] == 4'h0) && lz_upper[gi+1];
  end
  // Digit 0 always shows its glyph so a zero value still reads "0".
  assign glyph = ((idx_q != '0) && lz_upper[idx_q]) ? 7'h00 : hex_glyph(nib[idx_q]);
`else
  assign glyph = hex_glyph(nib[idx_q]);
`endif

  // Next-state logic: prescaler, scan index, guard gap, double buffer, outputs.
  always_comb begin
    pre_d       = tick ? '0 : pre_q + PRE_W'(1);
    idx_d       = idx_q;
    guard_d     = guard_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;

    if (tick) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      guard_d = GUARD_V;
    end else if (guard_q != '0) begin
      guard_d = guard_q - GRD_W'(1);
    end

    if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end

    // Frame boundary: a coincident load goes straight to the display,
    // otherwise any pending value is promoted. Either way nothing stays pending.
    if (wrap) begin
      if (load) begin
        disp_val_d  = value;
        disp_dp_d   = dp;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        disp_val_d  = pend_val_q;
        disp_dp_d   = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end

    seg_d = {disp_dp_q[idx_q], glyph} ^ SEG_INV;
    dig_d = (((guard_q == '0) && !blank) ? onehot : '0) ^ DIG_INV;
  end

  // State and output registers. frame_done goes through two stages so its
  // pulse lines up with the first output cycle that shows digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      guard_q      <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_INV;
      dig_q        <= DIG_INV;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      wrap_q       <= wrap;
      frame_done_q <= wrap_q;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign sevenseg   = seg_q;
  assign digit_en   = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: DIV=10, GUARD=2, four digits, active-high.
// Frame cycle c=0 is the cycle frame_done is high; digit d is shown during
// c=10d..10d+9 with digit_en off for the first two of those cycles.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset, load, blank;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  sevenseg;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] exp_plain;   // {digit3, digit2, digit1, digit0} sevenseg
    logic [31:0] exp_lz;      // same, with leading-zero blanking
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] sb_q [$];
  logic [31:0] cur;
  logic [31:0] rst_exp;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(100), .SCAN_HZ(10), .GUARD(2),
    .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .blank(blank), .sevenseg(sevenseg), .digit_en(digit_en),
    .frame_done(frame_done)
  );

  function automatic logic [31:0] pick(input vec_t v);
`ifdef SEG7_LZB_EN
    return v.exp_lz;
`else
    return v.exp_plain;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Advance until frame_done is seen, bounded.
  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " frame_done seen"}, 32'(frame_done), 32'd1);
  endtask

  // Check one full frame starting at its frame_done cycle, driving up to two
  // loads and a blank window at given frame cycles (-1 = unused).
  task automatic check_frame(input logic [31:0] segs, input int bon, input int boff,
                             input int lc1, input logic [15:0] lv1, input logic [3:0] ld1,
                             input int lc2, input logic [15:0] lv2, input logic [3:0] ld2,
                             input string tag);
    for (int c = 0; c < 40; c++) begin
      int d;
      int k;
      logic [3:0] en_e;
      d = c / 10;
      k = c % 10;
      en_e = (k < 2 || (c > bon && c <= boff)) ? 4'b0000 : (4'b0001 << d);
      chk($sformatf("%s seg c%0d", tag, c), 32'(sevenseg), 32'(segs[8*d +: 8]));
      chk($sformatf("%s digit_en c%0d", tag, c), 32'(digit_en), 32'(en_e));
      chk($sformatf("%s frame_done c%0d", tag, c), 32'(frame_done), 32'(c == 0));
      load = 1'b0;
      if (c == lc1) begin load = 1'b1; value = lv1; dp = ld1; end
      if (c == lc2) begin load = 1'b1; value = lv2; dp = ld2; end
      if (c == bon)  blank = 1'b1;
      if (c == boff) blank = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    $display("frame %s shown=%h checks=%0d failures=%0d", tag, segs, checks, failures);
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp = '0;

    vecs[0] = '{16'h12AF, 4'b0010, 32'h065BF771, 32'h065BF771};
    vecs[1] = '{16'h0000, 4'b0000, 32'h3F3F3F3F, 32'h0000003F};
    vecs[2] = '{16'h89E3, 4'b1001, 32'hFF6F79CF, 32'hFF6F79CF};
    vecs[3] = '{16'h0005, 4'b0000, 32'h3F3F3F6D, 32'h0000006D};
    vecs[4] = '{16'h4567, 4'b0100, 32'h66ED7D07, 32'h66ED7D07};
    vecs[5] = '{16'h0050, 4'b1000, 32'hBF3F6D3F, 32'h80006D3F};
    vecs[6] = '{16'hBCD0, 4'b0000, 32'h7C395E3F, 32'h7C395E3F};
`ifdef SEG7_LZB_EN
    rst_exp = 32'h0000003F;
`else
    rst_exp = 32'h3F3F3F3F;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset seg", 32'(sevenseg), 32'h00);
    chk("reset digit_en", 32'(digit_en), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    $display("reset checked");
    reset = 1'b0;
    sb_q.push_back(rst_exp);

    n = 0;
    while (digit_en !== 4'b0001 && n < 12) begin @(negedge clk); n++; end
    chk("post-reset digit_en", 32'(digit_en), 32'h1);
    chk("post-reset seg", 32'(sevenseg), 32'h3F);

    wait_frame("first");
    cur = sb_q.pop_front();

    // Table: each frame checks the shown value and loads the next mid-frame.
    foreach (vecs[i]) begin
      sb_q.push_back(pick(vecs[i]));
      check_frame(cur, -1, -1, 5, vecs[i].value, vecs[i].dp, -1, '0, '0,
                  $sformatf("vec%0d", i));
      cur = sb_q.pop_front();
    end

    // Tear-free: load while digit 2 is shown; old value holds to the wrap.
    sb_q.push_back(32'h4F3906F9);
    check_frame(cur, -1, -1, 25, 16'h3C1E, 4'b0001, -1, '0, '0, "tearfree_old");
    cur = sb_q.pop_front();

    // Coincident load at the wrap tick overrides an earlier pending load.
    sb_q.push_back(32'h713F5E6F);
    check_frame(cur, -1, -1, 10, 16'h7777, 4'b0000, 38, 16'hF0D9, 4'b0000, "coinc_old");
    cur = sb_q.pop_front();
    check_frame(cur, -1, -1, -1, '0, '0, -1, '0, '0, "coinc_new");
    check_frame(cur, -1, -1, -1, '0, '0, -1, '0, '0, "coinc_hold");

    // blank high for 15 cycles (c3..c17 sampled), digit_en off c4..c18.
    check_frame(cur, 3, 18, -1, '0, '0, -1, '0, '0, "blank");

    // Reset mid-frame with a load pending.
    repeat (5) @(negedge clk);
    load = 1'b1; value = 16'h8888; dp = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset seg", 32'(sevenseg), 32'h00);
    chk("midreset digit_en", 32'(digit_en), 32'h0);
    chk("midreset frame_done", 32'(frame_done), 32'h0);
    sb_q.push_back(rst_exp);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (digit_en !== 4'b0001 && n < 12) begin @(negedge clk); n++; end
    chk("midreset resume digit_en", 32'(digit_en), 32'h1);
    chk("midreset resume seg", 32'(sevenseg), 32'h3F);
    wait_frame("after_reset");
    cur = sb_q.pop_front();
    check_frame(cur, -1, -1, -1, '0, '0, -1, '0, '0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
